// File: rtl/switch_operand_loader.sv
// Board input front end: synchronizes and debounces active-low buttons, captures switch
// operands on press edges and hands a complete {A, B, Op, cin} command to the CPU.
module switch_operand_loader #(
    parameter int DATA_W          = 10,
    parameter int OPERAND_W       = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    data_in,
    input  logic                 A_button,
    input  logic                 B_button,
    input  logic                 Op_button,
    input  logic                 cin_button,
    output logic [OPERAND_W-1:0] A,
    output logic [OPERAND_W-1:0] B,
    output logic [7:0]           Op,
    output logic                 cin,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [2:0]           loaded,
    output logic [7:0]           drop_cnt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, ISSUE} state_t;

    function automatic logic [1:0] count3(input logic [2:0] bits);
        return {1'b0, bits[0]} + {1'b0, bits[1]} + {1'b0, bits[2]};
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] acc, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, acc} + {7'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // Button order in every vector: {cin, Op, B, A}.
    logic [3:0]        btn_p0, btn_p1;
    logic [3:0]        deb;
    logic [2:0]        deb_d;
    logic [2:0]        press_p3;
    logic [CNT_W-1:0]  cnt [4];
    logic [DATA_W-1:0] data_p0, data_p1;

    state_t     state, state_nxt;
    logic [2:0] loaded_nxt;
    logic       capture, issue_go, handshake;

    // Stage p0/p1: two-flop synchronizers; p2: debounce; p3: registered press pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_p0   <= '1;
            btn_p1   <= '1;
            deb      <= '1;
            deb_d    <= '1;
            press_p3 <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            btn_p0 <= {cin_button, Op_button, B_button, A_button};
            btn_p1 <= btn_p0;
            for (int i = 0; i < 4; i++) begin
                if (btn_p1[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= btn_p1[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            deb_d    <= deb[2:0];
            press_p3 <= deb_d & ~deb[2:0];
        end
    end

    // Switch data follows the same two-flop delay as the buttons.
    always_ff @(posedge clk) begin
        data_p0 <= data_in;
        data_p1 <= data_p0;
    end

    assign loaded_nxt = loaded | press_p3;
    assign cmd_valid  = (state == ISSUE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        issue_go  = 1'b0;
        handshake = 1'b0;
        case (state)
            IDLE, COLLECT: begin
                capture = 1'b1;
                if (loaded_nxt == 3'b111) begin
                    state_nxt = ISSUE;
                    issue_go  = 1'b1;
                end else if (|press_p3) begin
                    state_nxt = COLLECT;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    state_nxt = IDLE;
                    handshake = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand registers are frozen while a command is outstanding; late presses only count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            A        <= '0;
            B        <= '0;
            Op       <= '0;
            cin      <= 1'b0;
            loaded   <= '0;
            drop_cnt <= '0;
        end else begin
            if (capture) begin
                if (press_p3[0]) A  <= OPERAND_W'(data_p1);
                if (press_p3[1]) B  <= OPERAND_W'(data_p1);
                if (press_p3[2]) Op <= data_p1[7:0];
                loaded <= loaded_nxt;
            end
            if (issue_go) cin <= ~deb[3];
            if (state == ISSUE) drop_cnt <= sat_add(drop_cnt, count3(press_p3));
            if (handshake) loaded <= '0;
        end
    end

endmodule
